// File: rtl/fifo_rd_pkg.sv
// ---------------------------------------------------------------------------
// fifo_rd_pkg
// Shared types and width helpers for the FIFO read-side stream master.
//   rd_state_e  : controller state (run, flush drain, flush tail)
//   cnt_width() : bits needed to index/count n items (at least 1)
// ---------------------------------------------------------------------------
package fifo_rd_pkg;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_FLUSH = 2'd1,
      ST_TAIL  = 2'd2
   } rd_state_e;

   // Bits to hold values 0..n-1; occupancy of a depth-D buffer uses cnt_width(D+1).
   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/fifo_rd_buf.sv
// ---------------------------------------------------------------------------
// fifo_rd_buf
// Small circular prefetch buffer holding words already read from the FIFO.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   push        : write push_data at the tail
//   push_data   : word to store
//   pop         : advance the head
//   clr         : drop all contents (wins over push/pop)
//   head_data   : word at the head (zero after reset)
//   occ         : number of stored words
// The caller never pushes when full nor pops when empty.
// ---------------------------------------------------------------------------
module fifo_rd_buf
   import fifo_rd_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int BUF_DEPTH = 3,
   localparam int PTR_W    = cnt_width(BUF_DEPTH),
   localparam int OCC_W    = cnt_width(BUF_DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   input  logic             clr,
   output logic [WIDTH-1:0] head_data,
   output logic [OCC_W-1:0] occ
);

   logic [WIDTH-1:0] mem [BUF_DEPTH];
   logic [PTR_W-1:0] head_q;
   logic [PTR_W-1:0] tail_q;
   logic [OCC_W-1:0] occ_q;

   // Pointers wrap at BUF_DEPTH, which need not be a power of two.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < BUF_DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (push && !clr) begin
         mem[tail_q] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q <= '0;
         tail_q <= '0;
         occ_q  <= '0;
      end else if (clr) begin
         head_q <= '0;
         tail_q <= '0;
         occ_q  <= '0;
      end else begin
         if (push) begin
            tail_q <= ptr_inc(tail_q);
         end
         if (pop) begin
            head_q <= ptr_inc(head_q);
         end
         case ({push, pop})
            2'b10:   occ_q <= occ_q + OCC_W'(1);
            2'b01:   occ_q <= occ_q - OCC_W'(1);
            default: occ_q <= occ_q;
         endcase
      end
   end

   assign head_data = mem[head_q];
   assign occ       = occ_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// ---------------------------------------------------------------------------
// fifo_rd_stream
// Read-side master for the synchronous FIFO. Issues read enables, absorbs the
// FIFO's one-cycle read latency in a prefetch buffer and presents the words as
// a valid/ready stream. out_ready never reaches fifo_rd_en combinationally:
// the read decision looks only at buffer occupancy plus the in-flight read.
// A flush pulse drops buffered words and drains the upstream FIFO.
//
// Optional feature macro: FIFO_RD_LAST_EN adds out_last and a beat counter
// that marks every BURST_LEN-th accepted beat.
//
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   fifo_empty    : FIFO empty flag
//   fifo_rd_en    : FIFO read request
//   fifo_rd_data  : FIFO read data, valid the cycle after fifo_rd_en
//   flush         : single-cycle pulse, discard buffer and FIFO contents
//   out_valid     : stream valid
//   out_ready     : stream sink ready
//   out_data      : stream data (buffer head)
//   out_last      : last beat of a burst (FIFO_RD_LAST_EN only)
//   busy          : flush in progress
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_RUN   | normal streaming; prefetch while room for buffered + in-flight
// ST_FLUSH | reading and discarding FIFO words until it reports empty
// ST_TAIL  | one cycle to discard the last in-flight word, then ST_RUN
// ---------------------------------------------------------------------------
module fifo_rd_stream
   import fifo_rd_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int BUF_DEPTH = 3,
   parameter int BURST_LEN = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             fifo_empty,
   output logic             fifo_rd_en,
   input  logic [WIDTH-1:0] fifo_rd_data,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
`ifdef FIFO_RD_LAST_EN
   output logic             out_last,
`endif
   output logic             busy
);

   localparam int OCC_W = cnt_width(BUF_DEPTH + 1);
   localparam logic [OCC_W:0] DEPTH_V = (OCC_W + 1)'(BUF_DEPTH);

   if (BUF_DEPTH < 2) begin : g_bad_depth
      $error("fifo_rd_stream: BUF_DEPTH must be at least 2");
   end
   if (BURST_LEN < 1) begin : g_bad_burst
      $error("fifo_rd_stream: BURST_LEN must be at least 1");
   end

   rd_state_e        state_q;
   rd_state_e        state_d;
   logic             run_q;
   logic             pend_q;
   logic [OCC_W-1:0] occ;
   logic [OCC_W:0]   inflight;
   logic             buf_push;
   logic             buf_pop;
   logic             buf_clr;

   fifo_rd_buf #(
      .WIDTH     (WIDTH),
      .BUF_DEPTH (BUF_DEPTH)
   ) u_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (buf_push),
      .push_data (fifo_rd_data),
      .pop       (buf_pop),
      .clr       (buf_clr),
      .head_data (out_data),
      .occ       (occ)
   );

   // Words already buffered plus the one landing this cycle.
   assign inflight = {1'b0, occ} + {{OCC_W{1'b0}}, pend_q};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_RUN;
         run_q   <= 1'b0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         run_q   <= 1'b1;
         pend_q  <= fifo_rd_en;
      end
   end

   always_comb begin
      state_d    = state_q;
      fifo_rd_en = 1'b0;
      out_valid  = 1'b0;
      busy       = 1'b0;
      buf_push   = 1'b0;
      buf_pop    = 1'b0;
      buf_clr    = 1'b0;
      case (state_q)
         ST_RUN: begin
            out_valid  = (occ != '0);
            buf_pop    = out_valid && out_ready;
            fifo_rd_en = run_q && !fifo_empty && !flush && (inflight < DEPTH_V);
            if (flush) begin
               // The handshake of this cycle still completes; everything else,
               // including the word landing now, is dropped.
               buf_clr = 1'b1;
               state_d = ST_FLUSH;
            end else begin
               buf_push = pend_q;
            end
         end
         ST_FLUSH: begin
            busy       = 1'b1;
            fifo_rd_en = run_q && !fifo_empty;
            if (fifo_empty) begin
               state_d = ST_TAIL;
            end
         end
         ST_TAIL: begin
            busy    = 1'b1;
            state_d = ST_RUN;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

`ifdef FIFO_RD_LAST_EN
   localparam int CNT_W = cnt_width(BURST_LEN);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if ((state_q == ST_RUN) && flush) begin
         cnt_q <= '0;
      end else if (buf_pop) begin
         cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
      end
   end

   assign out_last = out_valid && (cnt_q == CNT_LAST);
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
module tb_fifo_rd_stream;

   localparam int WIDTH     = 8;
   localparam int BUF_DEPTH = 3;
   localparam int BURST_LEN = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             fifo_empty = 1'b1;
   logic             fifo_rd_en;
   logic [WIDTH-1:0] fifo_rd_data = '0;
   logic             flush = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] out_data;
   logic             busy;
`ifdef FIFO_RD_LAST_EN
   logic             out_last;
`endif

   logic             wr_en = 1'b0;
   logic [WIDTH-1:0] wr_data = '0;

   logic [WIDTH-1:0] fq[$];     // upstream FIFO contents
   logic [WIDTH-1:0] exp_q[$];  // words the stream still owes, in order

   int n_checks = 0;
   int n_fail = 0;
   int held = 0;      // reads issued minus beats accepted since last empty point
   int beats = 0;
   int cnt_m = 0;     // accepted beats since reset/flush
   int last_beats = 0;
   logic             prev_stall = 1'b0;
   logic [WIDTH-1:0] prev_data = '0;

   fifo_rd_stream #(
      .WIDTH     (WIDTH),
      .BUF_DEPTH (BUF_DEPTH),
      .BURST_LEN (BURST_LEN)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .fifo_empty   (fifo_empty),
      .fifo_rd_en   (fifo_rd_en),
      .fifo_rd_data (fifo_rd_data),
      .flush        (flush),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
`ifdef FIFO_RD_LAST_EN
      .out_last     (out_last),
`endif
      .busy         (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // Synchronous FIFO: registered read data and registered empty flag.
   always @(posedge clk) begin
      if (fifo_rd_en && fq.size() != 0) fifo_rd_data <= fq.pop_front();
      if (wr_en) begin
         fq.push_back(wr_data);
         exp_q.push_back(wr_data);
      end
      fifo_empty <= (fq.size() == 0);
   end

   // Per-cycle compare against the stream rules.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
         held = 0;
         cnt_m = 0;
         check("reset_out_valid", out_valid, 0);
         check("reset_busy", busy, 0);
         check("reset_rd_en", fifo_rd_en, 0);
         check("reset_out_data", out_data, 0);
      end else begin
         check("rd_en_while_empty", fifo_rd_en && fifo_empty, 0);
         if (busy) begin
            check("valid_while_busy", out_valid, 0);
            held = 0;
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               check("stall_keeps_valid", out_valid, 1);
               check("stall_keeps_data", out_data, prev_data);
            end
            check("rd_en_buffer_limit", fifo_rd_en && (held >= BUF_DEPTH), 0);
`ifdef FIFO_RD_LAST_EN
            check("out_last", out_last, out_valid && ((cnt_m % BURST_LEN) == BURST_LEN - 1));
            if (out_last && out_valid && out_ready) last_beats++;
`endif
            if (out_valid && out_ready) begin
               beats++;
               check("beat_was_owed", exp_q.size() != 0, 1);
               if (exp_q.size() != 0) check("beat_data", out_data, exp_q.pop_front());
               cnt_m++;
               held--;
            end
            if (fifo_rd_en) held++;
            prev_stall = out_valid && !out_ready && !flush;
            prev_data = out_data;
            if (flush) begin
               check("rd_en_at_flush", fifo_rd_en, 0);
               exp_q.delete();
               held = 0;
               cnt_m = 0;
               prev_stall = 1'b0;
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write(input logic [WIDTH-1:0] d);
      wr_en = 1'b1;
      wr_data = d;
      step();
      wr_en = 1'b0;
   endtask

   task automatic drain(input string name, input int max);
      int k = 0;
      step();
      out_ready = 1'b1;
      while ((exp_q.size() != 0 || out_valid || !fifo_empty) && k < max) begin
         step();
         k++;
      end
      check(name, exp_q.size(), 0);
      out_ready = 1'b0;
   endtask

   task automatic pulse_flush_and_wait(input string name);
      int k = 0;
      wr_en = 1'b0;
      flush = 1'b1;
      step();
      flush = 1'b0;
      while (busy && k < 300) begin
         step();
         k++;
      end
      check(name, busy, 0);
   endtask

   initial begin
      int s;
      int nb;
      int b0;
      int k;
      logic [WIDTH-1:0] first_w;

      // 1: reset release with one word waiting, read latency.
      write(8'h11);
      step();
      step();
      rst_n = 1'b1;
      @(negedge clk); check("t1_rd_en_first_cycle", fifo_rd_en, 0);
      @(negedge clk); check("t1_rd_en_issued", fifo_rd_en, 1);
      @(negedge clk); check("t1_valid_before_land", out_valid, 0);
      @(negedge clk); check("t1_valid_rises", out_valid, 1);
      check("t1_data", out_data, 8'h11);
      drain("t1_drain", 20);

      // 2: full throughput on 16 preloaded words.
      for (int i = 0; i < 16; i++) write(WIDTH'(i));
      step(); step(); step();
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         check("t2_beat_valid", out_valid, 1);
         check("t2_beat_data", out_data, i);
      end
      @(negedge clk); check("t2_valid_after_last", out_valid, 0);
      step();
      out_ready = 1'b0;

      // 3: alternating ready with random stalls, then random traffic and flushes.
      for (int i = 0; i < 16; i++) write(WIDTH'(i));
      for (int i = 0; i < 80; i++) begin
         out_ready = ((i % 2) == 0) && ($urandom_range(0, 3) != 0);
         step();
      end
      drain("t3_drain_alt", 60);
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 40) == 0) begin
            out_ready = ($urandom_range(0, 1) == 1);
            pulse_flush_and_wait("t3_flush_ends");
         end else begin
            wr_en = ($urandom_range(0, 1) == 1);
            wr_data = WIDTH'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
         end
      end
      wr_en = 1'b0;
      drain("t3_drain_random", 200);

      // 4: flush with words buffered and in the FIFO.
      for (int i = 0; i < 8; i++) write(WIDTH'(8'h40 + i));
      step(); step(); step(); step();
      b0 = beats;
      out_ready = 1'b1;
      step(); step();
      out_ready = 1'b0;
      check("t4_two_accepted", beats - b0, 2);
      step();
      flush = 1'b1;
      @(negedge clk);
      s = fq.size();
      check("t4_busy_low_in_flush_cycle", busy, 0);
      step();
      flush = 1'b0;
      nb = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (busy) nb++;
         else break;
      end
      check("t4_busy_cycles", nb, s + 2);
      check("t4_fifo_empty_after", fifo_empty, 1);
      check("t4_fifo_drained", fq.size(), 0);
      check("t4_no_beats", beats - b0, 2);
      step();
      write(8'hA5);
      k = 0;
      while (!out_valid && k < 10) begin step(); k++; end
      check("t4_new_word_valid", out_valid, 1);
      check("t4_new_word_data", out_data, 8'hA5);
      drain("t4_drain", 20);

      // 5: reset in the middle of streaming.
      for (int i = 0; i < 6; i++) write(WIDTH'(8'hC0 + i));
      step();
      #1;
      rst_n = 1'b0;
      #1;
      check("t5_valid_drops", out_valid, 0);
      check("t5_busy_low", busy, 0);
      check("t5_rd_en_low", fifo_rd_en, 0);
      exp_q = fq;
      first_w = exp_q[0];
      step(); step();
      rst_n = 1'b1;
      k = 0;
      while (!out_valid && k < 10) begin step(); k++; end
      check("t5_resume_valid", out_valid, 1);
      check("t5_resume_data", out_data, first_w);
      drain("t5_drain", 40);

`ifdef FIFO_RD_LAST_EN
      // 6: burst marker, cleared by flush.
      last_beats = 0;
      b0 = beats;
      for (int i = 0; i < 9; i++) write(WIDTH'(8'h60 + i));
      drain("t6_drain_a", 40);
      check("t6_beats_a", beats - b0, 9);
      check("t6_lasts_a", last_beats, 2);
      pulse_flush_and_wait("t6_flush_ends");
      for (int i = 0; i < 4; i++) write(WIDTH'(8'h70 + i));
      drain("t6_drain_b", 40);
      check("t6_lasts_b", last_beats, 3);
`endif

      step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
